// File: rtl/game_state_controller.sv
// Game state sequencer for the puzzle map drawer: owns the gameState code,
// the drawMap/doneRedraw redraw handshake and the timed UPDATE -> FORMED hold.
//
// phase      | meaning
// -----------+------------------------------------------------------------
// PH_LAUNCH  | out of reset, drawMap low for one cycle before first request
// PH_REQ     | drawMap high, waiting for the drawer to report done
// PH_RELEASE | drawMap low, waiting for the drawer to leave its done state
// PH_HOLD    | UPDATE_* frame on screen, counting ANIM_DELAY cycles
// PH_ADVANCE | step gameState to its automatic successor, then request
// PH_IDLE    | not busy, waiting for an act from the player
module game_state_controller #(
  parameter logic [21:0] ANIM_DELAY = 22'd2_500_000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       action,
  input  logic       atTrigger,
  input  logic       doneRedraw,
  output logic [3:0] gameState,
  output logic       drawMap,
  output logic       busy
);

  localparam logic [3:0] ST_INITIAL         = 4'd0;
  localparam logic [3:0] ST_UPDATE_BRIDGE_1 = 4'd1;
  localparam logic [3:0] ST_FORMED_BRIDGE_1 = 4'd2;
  localparam logic [3:0] ST_UPDATE_BRIDGE_2 = 4'd3;
  localparam logic [3:0] ST_FORMED_BRIDGE_2 = 4'd4;
  localparam logic [3:0] ST_UPDATE_BRIDGE_3 = 4'd5;
  localparam logic [3:0] ST_FORMED_BRIDGE_3 = 4'd6;
  localparam logic [3:0] ST_UPDATE_PILLAR   = 4'd7;
  localparam logic [3:0] ST_PILLAR_RISED    = 4'd8;
  localparam logic [3:0] ST_FINISHED_GAME   = 4'd9;
  localparam logic [3:0] ST_DRAW_INITIAL    = 4'd10;

  localparam logic [21:0] HOLD_LAST = ANIM_DELAY - 22'd1;

  typedef enum logic [2:0] {
    PH_LAUNCH,
    PH_REQ,
    PH_RELEASE,
    PH_HOLD,
    PH_ADVANCE,
    PH_IDLE
  } phase_t;

  phase_t      phase;
  logic [21:0] hold_cnt;
  logic        action_prev;
  logic        action_rise;
  logic        act;

  function automatic logic is_valid_state(input logic [3:0] s);
    return (s <= ST_DRAW_INITIAL);
  endfunction

  function automatic logic is_update_state(input logic [3:0] s);
    return (s == ST_UPDATE_BRIDGE_1) || (s == ST_UPDATE_BRIDGE_2) ||
           (s == ST_UPDATE_BRIDGE_3) || (s == ST_UPDATE_PILLAR);
  endfunction

  function automatic logic is_act_state(input logic [3:0] s);
    return (s == ST_INITIAL) || (s == ST_FORMED_BRIDGE_1) ||
           (s == ST_FORMED_BRIDGE_2) || (s == ST_FORMED_BRIDGE_3) ||
           (s == ST_PILLAR_RISED) || (s == ST_FINISHED_GAME);
  endfunction

  // Successor taken when the player acts in a waiting state.
  function automatic logic [3:0] act_next(input logic [3:0] s);
    logic [3:0] n;
    n = ST_DRAW_INITIAL;
    case (s)
      ST_INITIAL:         n = ST_UPDATE_BRIDGE_1;
      ST_FORMED_BRIDGE_1: n = ST_UPDATE_BRIDGE_2;
      ST_FORMED_BRIDGE_2: n = ST_UPDATE_BRIDGE_3;
      ST_FORMED_BRIDGE_3: n = ST_UPDATE_PILLAR;
      ST_PILLAR_RISED:    n = ST_FINISHED_GAME;
      ST_FINISHED_GAME:   n = ST_DRAW_INITIAL;
      default:            n = ST_DRAW_INITIAL;
    endcase
    return n;
  endfunction

  // Successor taken automatically once the redraw (and hold) completes.
  function automatic logic [3:0] advance_next(input logic [3:0] s);
    logic [3:0] n;
    n = ST_DRAW_INITIAL;
    case (s)
      ST_DRAW_INITIAL:    n = ST_INITIAL;
      ST_UPDATE_BRIDGE_1: n = ST_FORMED_BRIDGE_1;
      ST_UPDATE_BRIDGE_2: n = ST_FORMED_BRIDGE_2;
      ST_UPDATE_BRIDGE_3: n = ST_FORMED_BRIDGE_3;
      ST_UPDATE_PILLAR:   n = ST_PILLAR_RISED;
      default:            n = ST_DRAW_INITIAL;
    endcase
    return n;
  endfunction

  assign action_rise = action & ~action_prev;
  // busy is the registered IDLE flag, so an act in the cycle busy drops is taken.
  assign act = action_rise & ~busy &
               (atTrigger | (gameState == ST_FINISHED_GAME));

  always_ff @(posedge clock) begin
    if (reset) begin
      gameState   <= ST_DRAW_INITIAL;
      phase       <= PH_LAUNCH;
      drawMap     <= 1'b0;
      busy        <= 1'b1;
      hold_cnt    <= 22'd0;
      action_prev <= 1'b1;
    end else begin
      action_prev <= action;
      if (!is_valid_state(gameState)) begin
        gameState <= ST_DRAW_INITIAL;
        phase     <= PH_REQ;
        drawMap   <= 1'b1;
        busy      <= 1'b1;
        hold_cnt  <= 22'd0;
      end else begin
        case (phase)
          PH_LAUNCH: begin
            phase   <= PH_REQ;
            drawMap <= 1'b1;
            busy    <= 1'b1;
          end
          PH_REQ: begin
            if (doneRedraw) begin
              phase   <= PH_RELEASE;
              drawMap <= 1'b0;
            end
          end
          PH_RELEASE: begin
            if (!doneRedraw) begin
              if (is_update_state(gameState)) begin
                phase    <= (ANIM_DELAY == 22'd0) ? PH_ADVANCE : PH_HOLD;
                hold_cnt <= 22'd0;
              end else if (gameState == ST_DRAW_INITIAL) begin
                phase <= PH_ADVANCE;
              end else begin
                phase <= PH_IDLE;
                busy  <= 1'b0;
              end
            end
          end
          PH_HOLD: begin
            if (hold_cnt == HOLD_LAST) begin
              phase    <= PH_ADVANCE;
              hold_cnt <= 22'd0;
            end else begin
              hold_cnt <= hold_cnt + 22'd1;
            end
          end
          PH_ADVANCE: begin
            gameState <= advance_next(gameState);
            phase     <= PH_REQ;
            drawMap   <= 1'b1;
          end
          PH_IDLE: begin
            if (act && is_act_state(gameState)) begin
              gameState <= act_next(gameState);
              phase     <= PH_REQ;
              drawMap   <= 1'b1;
              busy      <= 1'b1;
            end
          end
          default: begin
            phase   <= PH_LAUNCH;
            drawMap <= 1'b0;
            busy    <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_game_state_controller.sv
// Directed bench for game_state_controller with a behavioural map-drawer model
// that raises doneRedraw draw_lat cycles into a request.
module tb_game_state_controller;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       action = 1'b0;
  logic       atTrigger = 1'b0;
  logic       doneRedraw = 1'b0;
  logic [3:0] gameState;
  logic       drawMap;
  logic       busy;

  int checks = 0;
  int failures = 0;
  int draw_lat = 50;
  int pulse_cnt = 0;
  logic dm_prev = 1'b0;

  game_state_controller #(.ANIM_DELAY(22'd3)) dut (
    .clock(clock),
    .reset(reset),
    .action(action),
    .atTrigger(atTrigger),
    .doneRedraw(doneRedraw),
    .gameState(gameState),
    .drawMap(drawMap),
    .busy(busy)
  );

  initial forever #5 clock = ~clock;

  // Drawer: done after draw_lat cycles of drawMap, leaves done once drawMap drops.
  initial begin
    int dcnt;
    dcnt = 0;
    forever begin
      @(posedge clock);
      #2;
      if (reset) begin
        doneRedraw = 1'b0;
        dcnt = 0;
      end else if (!doneRedraw) begin
        if (drawMap) begin
          dcnt++;
          if (dcnt >= draw_lat) begin
            doneRedraw = 1'b1;
            dcnt = 0;
          end
        end else begin
          dcnt = 0;
        end
      end else if (!drawMap) begin
        doneRedraw = 1'b0;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clock);
      #1;
      if (drawMap && !dm_prev) pulse_cnt++;
      dm_prev = drawMap;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic press();
    action = 1'b1;
    @(negedge clock);
    action = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 400) begin
      @(negedge clock);
      n++;
    end
    check(tag, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    logic [3:0] exp_press [6];
    logic [3:0] exp_idle [6];
    int p0, p1, last, n;

    exp_press[0] = 4'd1; exp_press[1] = 4'd3; exp_press[2] = 4'd5;
    exp_press[3] = 4'd7; exp_press[4] = 4'd9; exp_press[5] = 4'd10;
    exp_idle[0]  = 4'd2; exp_idle[1]  = 4'd4; exp_idle[2]  = 4'd6;
    exp_idle[3]  = 4'd8; exp_idle[4]  = 4'd9; exp_idle[5]  = 4'd0;

    // Reset and initial draw with a slow drawer
    reset = 1'b1;
    repeat (3) @(negedge clock);
    check("rst_gs", gameState, 10);
    check("rst_dm", drawMap, 0);
    check("rst_busy", busy, 1);
    p0 = pulse_cnt;
    reset = 1'b0;
    @(negedge clock);
    check("first_dm", drawMap, 1);
    check("first_gs", gameState, 10);
    n = 0;
    last = pulse_cnt;
    while (gameState !== 4'd0 && n < 500) begin
      last = pulse_cnt;
      @(negedge clock);
      n++;
    end
    check("init_reach_gs", gameState, 0);
    check("init_one_pulse_in_10", last - p0, 1);
    wait_idle("init_idle");
    check("init_idle_gs", gameState, 0);
    check("init_pulses", pulse_cnt - p0, 2);

    // Full walk, faster drawer
    draw_lat = 5;
    atTrigger = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i == 5) atTrigger = 1'b0;
      press();
      check("walk_press_gs", gameState, exp_press[i]);
      check("walk_press_dm", drawMap, 1);
      if (i == 0) begin
        n = 0;
        while (gameState === 4'd1 && n < 100) begin
          n++;
          @(negedge clock);
        end
        check("update_len", n, 10);
        check("formed_gs", gameState, 2);
        check("formed_dm", drawMap, 1);
      end
      if (i == 5) check("walk_pulses", pulse_cnt - p0, 12);
      wait_idle("walk_idle");
      check("walk_idle_gs", gameState, exp_idle[i]);
    end
    atTrigger = 1'b1;

    // Presses while busy are dropped
    p1 = pulse_cnt;
    press();
    check("busy_press_gs", gameState, 1);
    @(negedge clock);
    press();
    check("midreq_gs", gameState, 1);
    check("midreq_dm", drawMap, 1);
    n = 0;
    while (!(drawMap === 1'b0 && doneRedraw === 1'b0) && n < 100) begin
      @(negedge clock);
      n++;
    end
    @(negedge clock);
    press();
    check("midhold_gs", gameState, 1);
    check("midhold_busy", busy, 1);
    wait_idle("busy_idle");
    check("busy_idle_gs", gameState, 2);
    check("busy_pulses", pulse_cnt - p1, 2);

    // Key held through reset does not count as an edge
    reset = 1'b1;
    action = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    wait_idle("held_idle");
    check("held_reach_gs", gameState, 0);
    repeat (1000) @(negedge clock);
    check("held_gs", gameState, 0);
    check("held_busy", busy, 0);
    action = 1'b0;
    @(negedge clock);
    press();
    check("repress_gs", gameState, 1);
    wait_idle("repress_idle");

    // atTrigger gating in INITIAL
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    wait_idle("trig_idle");
    check("trig_start_gs", gameState, 0);
    atTrigger = 1'b0;
    press();
    @(negedge clock);
    check("notrig_gs", gameState, 0);
    check("notrig_busy", busy, 0);
    atTrigger = 1'b1;
    press();
    check("trig_gs", gameState, 1);
    check("trig_busy", busy, 1);
    wait_idle("trig_idle2");
    check("trig_formed_gs", gameState, 2);

    // Reset in the middle of UPDATE_BRIDGE_2's request
    press();
    check("ub2_gs", gameState, 3);
    check("ub2_dm", drawMap, 1);
    reset = 1'b1;
    @(negedge clock);
    check("rstmid_dm", drawMap, 0);
    check("rstmid_gs", gameState, 10);
    p1 = pulse_cnt;
    reset = 1'b0;
    @(negedge clock);
    check("rstmid_dm2", drawMap, 1);
    wait_idle("rstmid_idle");
    check("rstmid_idle_gs", gameState, 0);
    repeat (20) @(negedge clock);
    check("nostale_gs", gameState, 0);
    check("nostale_busy", busy, 0);
    check("nostale_pulses", pulse_cnt - p1, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
